// File: rtl/or_window_accum.sv
// or_window_accum: sticky-OR accumulator for the merged vector from the OR merge
// stage. Beats arrive on a valid/ready stream and are ORed together until in_last
// or until BEATS beats have been merged. Each closed window produces one result
// word together with its popcount and its beat count. The result is held until
// downstream accepts it. No new beat is taken while a result is pending, so there
// is always one bubble cycle between windows.
module or_window_accum #(
   parameter int W     = 8,
   parameter int BEATS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [W-1:0]                in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [W-1:0]                out_data,
   output logic [$clog2(W+1)-1:0]      out_pop,
   output logic [$clog2(BEATS+1)-1:0]  out_beats
);

   localparam int CW = $clog2(W+1);
   localparam int BW = $clog2(BEATS+1);

   typedef enum logic {
      S_ACCUM = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_acc;
   logic [BW-1:0]   r_cnt;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [W-1:0]    r_out_data;
   logic [CW-1:0]   r_out_pop;
   logic [BW-1:0]   r_out_beats;

   logic            w_accept;
   logic            w_close;
   logic [W-1:0]    w_merged;
   logic [BW-1:0]   w_cnt_next;
   logic [CW-1:0]   w_pop;

   // in_data only reaches the accumulator through w_accept, so an undriven bus
   // while in_valid is low never lands in r_acc.
   assign w_accept   = in_valid & r_in_ready;
   assign w_merged   = r_acc | in_data;
   assign w_cnt_next = r_cnt + BW'(1);
   assign w_close    = in_last | (w_cnt_next == BW'(BEATS));

   // Popcount of the value that would be stored if this beat closes the window.
   always_comb begin
      // NOTE: give every combinational output a value before the loop; a path
      // that leaves w_pop unassigned would infer a latch. Blocking '=' is the
      // right assignment here because each iteration reads the previous sum.
      w_pop = '0;
      for (int i = 0; i < W; i++) begin
         w_pop = w_pop + CW'(w_merged[i]);
      end
   end

   // Window FSM: accumulate beats in ACCUM, then present the result in HOLD
   // until it is taken. The handshake flags are registered along with the state.
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking '<=' so every register samples
      // pre-edge values. The datapath registers are reset as well because the
      // result outputs must read zero after reset.
      if (!rst_n) begin
         r_state     <= S_ACCUM;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_pop   <= '0;
         r_out_beats <= '0;
      end else begin
         case (r_state)
            S_ACCUM: begin
               if (w_accept) begin
                  if (w_close) begin
                     r_out_data  <= w_merged;
                     r_out_pop   <= w_pop;
                     r_out_beats <= w_cnt_next;
                     r_acc       <= '0;
                     r_cnt       <= '0;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_HOLD;
                  end else begin
                     r_acc <= w_merged;
                     r_cnt <= w_cnt_next;
                  end
               end
            end
            S_HOLD: begin
               // The result stays in the out registers after the transfer.
               // Only the handshake flags change.
               if (out_ready) begin
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_state     <= S_ACCUM;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_state     <= S_ACCUM;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_pop   = r_out_pop;
   assign out_beats = r_out_beats;

endmodule

// File: tb/tb_or_window_accum.sv
// Bench for or_window_accum. It instantiates two copies of the design:
//   - A: W=8, BEATS=4. Driven by directed windows and then by random traffic.
//   - B: W=8, BEATS=1. Driven by random traffic only.
// For each copy, a reference model runs on the falling edge. It gathers the
// accepted beats of each window in a queue and ORs them when the window closes.
// The expected result is pushed to a scoreboard queue. A separate monitor pops
// the queue and compares each result the DUT presents.
module tb_or_window_accum;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] pop;
      logic [2:0] beats;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
   logic [7:0] a_in_data, a_out_data;
   logic [3:0] a_out_pop;
   logic [2:0] a_out_beats;

   logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
   logic [7:0] b_in_data, b_out_data;
   logic [3:0] b_out_pop;
   logic [0:0] b_out_beats;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   chk_en   = 1'b0;

   // Model and scoreboard state.
   logic [7:0] a_win[$];
   res_t       a_q[$];
   bit         a_hold = 1'b0;
   res_t       a_last = '0;
   res_t       b_q[$];
   bit         b_hold = 1'b0;
   res_t       b_last = '0;
   int         b_acc_cnt = 0;
   int         b_xfer_cnt = 0;

   always #5 clk = ~clk;

   or_window_accum #(.W(8), .BEATS(4)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .in_last   (a_in_last),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .out_pop   (a_out_pop),
      .out_beats (a_out_beats)
   );

   or_window_accum #(.W(8), .BEATS(1)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .in_last   (b_in_last),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_pop   (b_out_pop),
      .out_beats (b_out_beats)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model A: sees the same inputs the DUT samples at the next rising edge.
   always @(negedge clk) begin
      logic [7:0] acc;
      if (chk_en) begin
         check("a_in_ready", a_in_ready, !a_hold);
         check("a_out_valid", a_out_valid, a_hold);
      end
      if (!rst_n) begin
         a_win.delete();
         a_q.delete();
         a_hold = 1'b0;
      end else if (a_hold) begin
         if (a_out_ready) a_hold = 1'b0;
      end else if (a_in_valid) begin
         a_win.push_back(a_in_data);
         if (a_in_last || a_win.size() == 4) begin
            acc = '0;
            foreach (a_win[i]) acc = acc | a_win[i];
            a_q.push_back('{data: acc, pop: 4'($countones(acc)), beats: 3'(a_win.size())});
            a_win.delete();
            a_hold = 1'b1;
         end
      end
   end

   // Monitor A: compare presented results, and held values between windows.
   always @(negedge clk) begin
      if (!rst_n) begin
         a_last = '0;
      end else if (chk_en) begin
         if (a_out_valid) begin
            check("a_q_depth", a_q.size(), 1);
            if (a_q.size() > 0) begin
               check("a_out_data", a_out_data, a_q[0].data);
               check("a_out_pop", a_out_pop, a_q[0].pop);
               check("a_out_beats", a_out_beats, a_q[0].beats);
               if (a_out_ready) a_last = a_q.pop_front();
            end
         end else begin
            check("a_held_data", a_out_data, a_last.data);
            check("a_held_pop", a_out_pop, a_last.pop);
            check("a_held_beats", a_out_beats, a_last.beats);
         end
      end
   end

   // Model B: with one beat per window, every accepted beat is a complete result.
   always @(negedge clk) begin
      if (chk_en) begin
         check("b_in_ready", b_in_ready, !b_hold);
         check("b_out_valid", b_out_valid, b_hold);
      end
      if (!rst_n) begin
         b_q.delete();
         b_hold = 1'b0;
      end else if (b_hold) begin
         if (b_out_ready) b_hold = 1'b0;
      end else if (b_in_valid) begin
         b_q.push_back('{data: b_in_data, pop: 4'($countones(b_in_data)), beats: 3'd1});
         b_acc_cnt++;
         b_hold = 1'b1;
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      if (!rst_n) begin
         b_last = '0;
      end else if (chk_en) begin
         if (b_out_valid) begin
            check("b_q_depth", b_q.size(), 1);
            if (b_q.size() > 0) begin
               check("b_out_data", b_out_data, b_q[0].data);
               check("b_out_pop", b_out_pop, b_q[0].pop);
               check("b_out_beats", b_out_beats, b_q[0].beats);
               if (b_out_ready) begin
                  b_last = b_q.pop_front();
                  b_xfer_cnt++;
               end
            end
         end else begin
            check("b_held_data", b_out_data, b_last.data);
            check("b_held_beats", b_out_beats, b_last.beats);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat to A and keep it valid until the model says it is taken.
   // The task returns #1 after the accepting edge.
   task automatic a_send(input logic [7:0] d, input logic l);
      bit ok;
      ok         = 1'b0;
      a_in_valid = 1'b1;
      a_in_data  = d;
      a_in_last  = l;
      for (int i = 0; i < 20; i++) begin
         if (!a_hold) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("a_send_accepted", ok, 1'b1);
      tick();
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      a_in_data  = 8'($urandom);
   endtask

   task automatic a_expect(input string name, input logic [7:0] d, input logic [3:0] p,
                           input logic [2:0] b);
      check({name, "_valid"}, a_out_valid, 1'b1);
      check({name, "_data"}, a_out_data, d);
      check({name, "_pop"}, a_out_pop, p);
      check({name, "_beats"}, a_out_beats, b);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      a_in_valid  = 1'b0; a_in_last = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
      b_in_valid  = 1'b0; b_in_last = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Reset state.
      check("rst_in_ready", a_in_ready, 1'b1);
      check("rst_out_valid", a_out_valid, 1'b0);
      check("rst_out_data", a_out_data, 8'h00);
      check("rst_out_pop", a_out_pop, 4'd0);
      check("rst_out_beats", a_out_beats, 3'd0);

      // Full window closed by the beat count; result one cycle after the 4th accept.
      a_send(8'h01, 1'b0); a_send(8'h02, 1'b0); a_send(8'h04, 1'b0);
      check("t1_no_early_valid", a_out_valid, 1'b0);
      a_send(8'h08, 1'b0);
      a_expect("t1", 8'h0F, 4'd4, 3'd4);
      tick();

      // Window closed by in_last, result stalled by out_ready=0.
      a_out_ready = 1'b0;
      a_send(8'h80, 1'b0); a_send(8'h01, 1'b1);
      a_expect("t2", 8'h81, 4'd2, 3'd2);
      check("t2_in_ready_hold", a_in_ready, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_in_ready_stall", a_in_ready, 1'b0);
         check("t3_data_stable", a_out_data, 8'h81);
      end
      a_out_ready = 1'b1;
      tick();
      check("t3_in_ready_back", a_in_ready, 1'b1);
      check("t3_valid_dropped", a_out_valid, 1'b0);
      check("t3_data_kept", a_out_data, 8'h81);

      // All ones and all zeros.
      a_send(8'hFF, 1'b0); a_send(8'hFF, 1'b0); a_send(8'h00, 1'b0); a_send(8'h00, 1'b0);
      a_expect("t4_ones", 8'hFF, 4'd8, 3'd4);
      tick();
      for (int i = 0; i < 4; i++) a_send(8'h00, 1'b0);
      a_expect("t4_zeros", 8'h00, 4'd0, 3'd4);
      tick();

      // in_last on the first beat.
      a_send(8'h3C, 1'b1);
      a_expect("first_last", 8'h3C, 4'd4, 3'd1);
      tick();

      // Reset mid-window, then reset during HOLD, then a fresh window.
      a_send(8'h11, 1'b0); a_send(8'h22, 1'b0);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t5_mid_valid", a_out_valid, 1'b0);
      check("t5_mid_ready", a_in_ready, 1'b1);
      check("t5_mid_data", a_out_data, 8'h00);
      a_out_ready = 1'b0;
      a_send(8'h05, 1'b0); a_send(8'h06, 1'b1);
      check("t5_hold_reached", a_out_valid, 1'b1);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t5_hold_valid", a_out_valid, 1'b0);
      check("t5_hold_data", a_out_data, 8'h00);
      check("t5_hold_beats", a_out_beats, 3'd0);
      a_out_ready = 1'b1;
      a_send(8'h10, 1'b0); a_send(8'h20, 1'b0); a_send(8'h40, 1'b0); a_send(8'h80, 1'b0);
      a_expect("t5_fresh", 8'hF0, 4'd4, 3'd4);
      tick();

      // Random traffic on both copies. Data is garbage whenever valid is low.
      for (int cyc = 0; cyc < 1000; cyc++) begin
         a_in_valid  = 1'($urandom_range(0, 1));
         a_in_data   = 8'($urandom);
         a_in_last   = ($urandom_range(0, 3) == 0);
         a_out_ready = 1'($urandom_range(0, 1));
         b_in_valid  = 1'($urandom_range(0, 1));
         b_in_data   = 8'($urandom);
         b_in_last   = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         tick();
      end

      // Drain any pending results.
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("a_drained", a_q.size(), 0);
      check("b_drained", b_q.size(), 0);
      check("b_no_loss_dup", b_xfer_cnt, b_acc_cnt);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
